// File: rtl/fulladder_test_pkg.sv
// Shared definitions for the full-adder self-test engine: FSM encoding,
// sweep size and the vector-index to adder-operand mapping.
package fulladder_test_pkg;

    localparam int NUM_VECTORS = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic carryin;
        logic b;
        logic a;
    } operands_t;

    // Bit 0 drives a, so the sweep walks a fastest and carryin slowest.
    function automatic operands_t vec_to_operands(input logic [2:0] vec);
        operands_t ops;
        ops.a       = vec[0];
        ops.b       = vec[1];
        ops.carryin = vec[2];
        return ops;
    endfunction

endpackage

// File: rtl/fulladder_golden.sv
// Combinational reference full adder used as the checker's golden model.
module fulladder_golden (
    input  logic a,
    input  logic b,
    input  logic carryin,
    output logic exp_sum,
    output logic exp_cout
);

    assign exp_sum  = a ^ b ^ carryin;
    assign exp_cout = (a & b) | (a & carryin) | (b & carryin);

endmodule

// File: rtl/fulladder_bist_checker.sv
// Self-test engine: sweeps all eight operand combinations into an external
// full adder, compares each settled response with the golden model, reports a verdict.
module fulladder_bist_checker
    import fulladder_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       carryin,
    input  logic       sum,
    input  logic       carryout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_VEC   = 3'(NUM_VECTORS - 1);

    state_t     state, state_nxt;
    logic [2:0] vec, vec_nxt;
    logic [3:0] cnt, cnt_nxt;
    operands_t  ops, ops_nxt;
    logic       busy_nxt, done_nxt, pass_nxt;
    logic [3:0] err_nxt;
    logic [2:0] ffv_nxt;
    logic       ffvalid_nxt;
    logic       exp_sum, exp_cout, mismatch;

    assign a       = ops.a;
    assign b       = ops.b;
    assign carryin = ops.carryin;

    // Golden model sees the registered stimulus, i.e. exactly what the adder sees.
    fulladder_golden u_golden (
        .a        (ops.a),
        .b        (ops.b),
        .carryin  (ops.carryin),
        .exp_sum  (exp_sum),
        .exp_cout (exp_cout)
    );

    assign mismatch = (sum != exp_sum) || (carryout != exp_cout);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        vec_nxt     = vec;
        cnt_nxt     = cnt;
        ops_nxt     = ops;
        busy_nxt    = busy;
        done_nxt    = done;
        pass_nxt    = pass;
        err_nxt     = err_count;
        ffv_nxt     = first_fail_vec;
        ffvalid_nxt = first_fail_valid;

        case (state)
            ST_IDLE, ST_DONE: begin
                ops_nxt = '0;
                if (start) begin
                    state_nxt   = ST_SETTLE;
                    vec_nxt     = '0;
                    cnt_nxt     = CNT_RELOAD;
                    ops_nxt     = vec_to_operands(3'd0);
                    busy_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    pass_nxt    = 1'b0;
                    err_nxt     = '0;
                    ffv_nxt     = '0;
                    ffvalid_nxt = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) state_nxt = ST_COMPARE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ST_COMPARE: begin
                if (mismatch) begin
                    err_nxt = err_count + 4'd1;
                    if (!first_fail_valid) begin
                        ffv_nxt     = vec;
                        ffvalid_nxt = 1'b1;
                    end
                end
                if (vec == LAST_VEC) begin
                    state_nxt = ST_DONE;
                    ops_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    // Verdict must include the compare happening on this edge.
                    pass_nxt  = (err_nxt == 4'd0);
                end else begin
                    state_nxt = ST_SETTLE;
                    vec_nxt   = vec + 3'd1;
                    cnt_nxt   = CNT_RELOAD;
                    ops_nxt   = vec_to_operands(vec + 3'd1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            vec              <= '0;
            cnt              <= '0;
            ops              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_nxt;
            vec              <= vec_nxt;
            cnt              <= cnt_nxt;
            ops              <= ops_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            pass             <= pass_nxt;
            err_count        <= err_nxt;
            first_fail_vec   <= ffv_nxt;
            first_fail_valid <= ffvalid_nxt;
        end
    end

endmodule

// File: tb/tb_fulladder_bist_checker.sv
// Directed bench: two checker instances (settle 4 and settle 1) each drive a
// behavioural adder with injectable faults; expected values are hand-computed.
module tb_fulladder_bist_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start4 = 1'b0;
    logic start1 = 1'b0;

    // 0: correct adder, 1: carryout stuck-at-0, 2: sum inverted
    int fault_mode = 0;

    logic       a4, b4, cin4, sum4, cout4, busy4, done4, pass4, ffvalid4;
    logic [3:0] err4;
    logic [2:0] ffv4;
    logic       a1, b1, cin1, sum1, cout1, busy1, done1, pass1, ffvalid1;
    logic [3:0] err1;
    logic [2:0] ffv1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fulladder_bist_checker #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .a(a4), .b(b4), .carryin(cin4),
        .sum(sum4), .carryout(cout4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_fail_vec(ffv4), .first_fail_valid(ffvalid4)
    );

    fulladder_bist_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .carryin(cin1),
        .sum(sum1), .carryout(cout1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
    );

    // Behavioural adders under test, with fault injection.
    always_comb begin
        sum4  = a4 ^ b4 ^ cin4;
        cout4 = (a4 & b4) | (a4 & cin4) | (b4 & cin4);
        if (fault_mode == 1) cout4 = 1'b0;
        if (fault_mode == 2) sum4  = ~sum4;
        sum1  = a1 ^ b1 ^ cin1;
        cout1 = (a1 & b1) | (a1 & cin1) | (b1 & cin1);
        if (fault_mode == 1) cout1 = 1'b0;
        if (fault_mode == 2) sum1  = ~sum1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Called #1 after a clock edge; counts edges after the start edge until done.
    // A second start is pulsed so that it is sampled at edge restart_at (0 = none).
    task automatic wait_done4(input int restart_at, output int edges);
        edges = 0;
        while (edges < 200) begin
            if (restart_at != 0 && edges + 1 == restart_at) start4 = 1'b1;
            @(posedge clk);
            #1 start4 = 1'b0;
            edges++;
            if (done4) break;
        end
    endtask

    task automatic sweep4(input int restart_at, output int edges);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        check("busy_after_start", busy4, 1);
        wait_done4(restart_at, edges);
    endtask

    task automatic check_verdict4(input string tag, input int edges, input logic p,
                                  input int err, input logic fv, input int fvec);
        check({tag, "_edges"}, edges, 40);
        check({tag, "_done"}, done4, 1);
        check({tag, "_busy"}, busy4, 0);
        check({tag, "_pass"}, pass4, p);
        check({tag, "_err"}, err4, err);
        check({tag, "_ffvalid"}, ffvalid4, fv);
        if (fv) check({tag, "_ffvec"}, ffv4, fvec);
        check({tag, "_ops_idle"}, {cin4, b4, a4}, 0);
    endtask

    initial begin
        int edges;
        logic [2:0] exp_ops [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                    3'b100, 3'b101, 3'b110, 3'b111};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_pass", pass4, 0);
        check("rst_err", err4, 0);
        check("rst_ffvalid", ffvalid4, 0);
        check("rst_ops", {cin4, b4, a4}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct adder: 40-cycle sweep, pass
        fault_mode = 0;
        sweep4(0, edges);
        check_verdict4("good", edges, 1'b1, 0, 1'b0, 0);

        // carryout stuck-at-0: vectors 3,5,6,7 fail
        fault_mode = 1;
        sweep4(0, edges);
        check_verdict4("cout_sa0", edges, 1'b0, 4, 1'b1, 3);

        // sum inverted: every vector fails
        fault_mode = 2;
        sweep4(0, edges);
        check_verdict4("sum_inv", edges, 1'b0, 8, 1'b1, 0);

        // Reset mid-sweep while vec=4 (after the compare of vector 3 at edge 20)
        fault_mode = 1;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        check("mid_ops_vec4", {cin4, b4, a4}, 3'b100);
        check("mid_err_before_rst", err4, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_err", err4, 0);
        check("mid_rst_ffvalid", ffvalid4, 0);
        check("mid_rst_ffvec", ffv4, 0);
        check("mid_rst_ops", {cin4, b4, a4}, 0);
        check("mid_rst_done", done4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fault_mode = 0;
        @(negedge clk);
        sweep4(0, edges);
        check_verdict4("after_rst", edges, 1'b1, 0, 1'b0, 0);

        // start while busy is ignored; completion still at edge 40
        fault_mode = 1;
        sweep4(10, edges);
        check_verdict4("restart_busy", edges, 1'b0, 4, 1'b1, 3);

        // start in DONE clears the previous results and runs a new sweep
        fault_mode = 0;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        check("done_restart_done", done4, 0);
        check("done_restart_busy", busy4, 1);
        check("done_restart_err", err4, 0);
        check("done_restart_ffvalid", ffvalid4, 0);
        wait_done4(0, edges);
        check_verdict4("done_restart", edges, 1'b1, 0, 1'b0, 0);

        // SETTLE_CYCLES=1: compares at edges 2,4,..,16; operands checked before each
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int v = 0; v < 8; v++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("s1_ops_vec%0d", v), {cin1, b1, a1}, exp_ops[v]);
            check($sformatf("s1_busy_vec%0d", v), busy1, 1);
            @(posedge clk);
        end
        #1;
        check("s1_done", done1, 1);
        check("s1_busy_end", busy1, 0);
        check("s1_pass", pass1, 1);
        check("s1_err", err1, 0);
        check("s1_ops_idle", {cin1, b1, a1}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
